odelay_scan_calib: RTL

- Calibration sequencer directly upstream of the ODELAY set controller. It drives that controller's 9-bit delay target and consumes its delay_ready flag.
- On start, it sweeps the target across the tap range and counts pattern-checker errors at each tap. It then finds the longest contiguous error-free run and parks delay_target at the centre of that run.
- One instance per serial lane, all in the clk160 domain.

---
 rtl/odelay_scan_calib_pkg.sv | 24 ++
 rtl/odelay_scan_calib_if.sv | 41 ++++
 rtl/odelay_scan_calib_eye_run_tracker.sv | 72 +++++++
 rtl/odelay_scan_calib.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/odelay_scan_calib_pkg.sv
// Shared types and constants for the ODELAY scan calibration sequencer.
package odelay_calib_pkg;

  localparam int TAP_W       = 9;
  localparam int READY_BLANK = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_WAIT_RDY,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_CENTER,
    ST_FINISH
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/odelay_scan_calib_if.sv
// Lane-side bundle between the calibration sequencer and its environment.
// Optional scan log signals exist only when SCAN_LOG_EN is defined.
interface odelay_scan_calib_if #(
  parameter int CNT_W = 16
);
  import odelay_calib_pkg::*;

  logic             start;
  logic             err_in;
  logic             delay_ready;
  logic [TAP_W-1:0] delay_target;
  logic             busy;
  logic             done;
  logic             fail;
  logic             timeout;
  logic [TAP_W-1:0] eye_start;
  logic [TAP_W-1:0] eye_len;
`ifdef SCAN_LOG_EN
  logic             log_valid;
  logic [TAP_W-1:0] log_tap;
  logic [CNT_W-1:0] log_err;
`endif

  // master: the sequencer; slave: pattern checker / delay controller side
  modport master (
    input  start, err_in, delay_ready,
    output delay_target, busy, done, fail, timeout, eye_start, eye_len
`ifdef SCAN_LOG_EN
    , output log_valid, log_tap, log_err
`endif
  );

  modport slave (
    output start, err_in, delay_ready,
    input  delay_target, busy, done, fail, timeout, eye_start, eye_len
`ifdef SCAN_LOG_EN
    , input log_valid, log_tap, log_err
`endif
  );

endinterface

// File: rtl/odelay_scan_calib_eye_run_tracker.sv
// Tracks the current contiguous passing run and keeps the longest one seen;
// ties keep the earlier run.
module eye_run_tracker
  import odelay_calib_pkg::*;
(
  input  logic             clk160,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic             pass_i,
  input  logic             flush_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic [TAP_W-1:0] best_start_o,
  output logic [TAP_W:0]   best_len_o
);

  logic [TAP_W-1:0] run_start_q, run_start_d;
  logic [TAP_W:0]   run_len_q, run_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [TAP_W:0]   best_len_q, best_len_d;
  logic [TAP_W-1:0] upd_start;
  logic [TAP_W:0]   upd_len;
  logic             close;

  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    upd_start    = run_start_q;
    upd_len      = run_len_q;
    close        = 1'b0;

    if (clear_i) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (step_i) begin
      if (pass_i) begin
        upd_start = (run_len_q == '0) ? tap_i : run_start_q;
        upd_len   = run_len_q + (TAP_W+1)'(1);
      end
      close       = !pass_i || flush_i;
      run_start_d = upd_start;
      run_len_d   = close ? '0 : upd_len;
      // strict compare so an equal-length later run never displaces the first
      if (close && (upd_len > best_len_q)) begin
        best_start_d = upd_start;
        best_len_d   = upd_len;
      end
    end
  end

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/odelay_scan_calib.sv
// Per-lane ODELAY eye scan: sweep taps, measure errors, park at eye centre.
// Define SCAN_LOG_EN to expose a per-tap log (log_valid/log_tap/log_err).
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for start
// SET       | drive delay_target = cur_tap
// WAIT_RDY  | wait for delay_ready (first READY_BLANK cycles ignored)
// SETTLE    | let the new tap settle before counting
// MEASURE   | count err_in over the window
// EVAL      | update run tracker, advance tap or finish sweep
// CENTER    | park at centre of best run
// FINISH    | done pulse, back to IDLE
module odelay_scan_calib
  import odelay_calib_pkg::*;
#(
  parameter int TAP_STEP     = 4,
  parameter int TAP_MAX      = 511,
  parameter int SETTLE_CYC   = 16,
  parameter int WINDOW_CYC   = 1024,
  parameter int READY_TO_CYC = 4096,
  parameter int CNT_W        = 16
) (
  input  logic               clk160,
  input  logic               rst,
  odelay_scan_calib_if.master bus
);

  localparam int TMR_W = $clog2(max3(READY_TO_CYC, SETTLE_CYC, WINDOW_CYC)) + 1;

  state_e           state_q, state_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic [TAP_W-1:0] tgt_q, tgt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [TAP_W-1:0] eye_start_q, eye_start_d;
  logic [TAP_W-1:0] eye_len_q, eye_len_d;

  logic             trk_clear, trk_step, trk_flush;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W:0]   best_len;
  logic [TAP_W:0]   next_tap;
  logic             ready_ok;

  eye_run_tracker u_trk (
    .clk160       (clk160),
    .rst          (rst),
    .clear_i      (trk_clear),
    .step_i       (trk_step),
    .pass_i       (err_cnt_q == '0),
    .flush_i      (trk_flush),
    .tap_i        (cur_tap_q),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

  assign next_tap = {1'b0, cur_tap_q} + (TAP_W+1)'(TAP_STEP);
  // delay_ready is combinational downstream and may still reflect the old tap
  assign ready_ok = ((TMR_W'(READY_TO_CYC - 1) - tmr_q) >= TMR_W'(READY_BLANK))
                    && bus.delay_ready;

  always_comb begin
    state_d     = state_q;
    cur_tap_d   = cur_tap_q;
    tgt_d       = tgt_q;
    tmr_d       = tmr_q;
    err_cnt_d   = err_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    eye_start_d = eye_start_q;
    eye_len_d   = eye_len_q;
    trk_clear   = 1'b0;
    trk_step    = 1'b0;
    trk_flush   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          trk_clear = 1'b1;
          cur_tap_d = '0;
          tgt_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_SET;
        end
      end
      ST_SET: begin
        tgt_d   = cur_tap_q;
        tmr_d   = TMR_W'(READY_TO_CYC - 1);
        state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (ready_ok) begin
          tmr_d   = TMR_W'(SETTLE_CYC - 1);
          state_d = ST_SETTLE;
        end else if (tmr_q == '0) begin
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          state_d   = ST_FINISH;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          err_cnt_d = '0;
          tmr_d     = TMR_W'(WINDOW_CYC - 1);
          state_d   = ST_MEASURE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        if (bus.err_in && (err_cnt_q != {CNT_W{1'b1}}))
          err_cnt_d = err_cnt_q + CNT_W'(1);
        if (tmr_q == '0) state_d = ST_EVAL;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_EVAL: begin
        trk_step = 1'b1;
        if (next_tap > (TAP_W+1)'(TAP_MAX)) begin
          trk_flush = 1'b1;
          state_d   = ST_CENTER;
        end else begin
          cur_tap_d = next_tap[TAP_W-1:0];
          state_d   = ST_SET;
        end
      end
      ST_CENTER: begin
        if (best_len == '0) begin
          fail_d = 1'b1;
          tgt_d  = '0;
        end else begin
          tgt_d = TAP_W'(20'(best_start)
                  + ((20'(best_len - (TAP_W+1)'(1)) * 20'(TAP_STEP)) >> 1));
        end
        eye_start_d = best_start;
        eye_len_d   = TAP_W'(best_len);
        state_d     = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // done rises and busy falls together, on the cycle FINISH is occupied
    if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_tap_q   <= '0;
      tgt_q       <= '0;
      tmr_q       <= '0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      eye_start_q <= '0;
      eye_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_tap_q   <= cur_tap_d;
      tgt_q       <= tgt_d;
      tmr_q       <= tmr_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      eye_start_q <= eye_start_d;
      eye_len_q   <= eye_len_d;
    end
  end

  assign bus.delay_target = tgt_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.timeout      = timeout_q;
  assign bus.eye_start    = eye_start_q;
  assign bus.eye_len      = eye_len_q;

`ifdef SCAN_LOG_EN
  assign bus.log_valid = (state_q == ST_EVAL);
  assign bus.log_tap   = cur_tap_q;
  assign bus.log_err   = err_cnt_q;
`endif

endmodule
